// File: rtl/cfi_violation_reporter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cfi_violation_reporter: queues CFI violations from two commit ports    |
// | into a record FIFO with drop/total counters. Optional halt handshake   |
// | enabled by defining CFI_REPORT_HALT_EN.                                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module cfi_violation_reporter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            viol_valid_i,
  input  logic [1:0][63:0]      viol_pc_i,
  input  logic [1:0][1:0]       viol_kind_i,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic [63:0]           rec_pc_o,
  output logic [1:0]            rec_kind_o,
  output logic                  rec_port_o,
  output logic                  irq_o,
  output logic [CNT_W-1:0]      total_cnt_o,
  output logic [CNT_W-1:0]      drop_cnt_o,
  input  logic                  clr_cnt_i
`ifdef CFI_REPORT_HALT_EN
  ,
  output logic                  halt_req_o,
  input  logic                  halt_ack_i
`endif
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  kind;
    logic        port;
  } rec_t;

  rec_t               r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_OCC_W-1:0] r_count;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_drop;

  logic               w_pop;
  logic [c_OCC_W-1:0] w_free;
  logic               w_acc0;
  logic               w_acc1;
  logic [1:0]         w_n_req;
  logic [1:0]         w_n_acc;
  logic [1:0]         w_n_drop;
  logic [c_PTR_W-1:0] w_wptr1;
  rec_t               w_head;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign w_pop = rec_valid_o & rec_ready_i;

  // Free space counts the slot released by this cycle's pop.
  assign w_free   = c_OCC_W'(DEPTH) - r_count + c_OCC_W'(w_pop);
  assign w_acc0   = viol_valid_i[0] && (w_free != '0);
  assign w_acc1   = viol_valid_i[1] &&
                    (w_acc0 ? (w_free >= c_OCC_W'(2)) : (w_free != '0));
  assign w_n_req  = {1'b0, viol_valid_i[0]} + {1'b0, viol_valid_i[1]};
  assign w_n_acc  = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_n_drop = w_n_req - w_n_acc;
  assign w_wptr1  = w_acc0 ? r_wptr + c_PTR_W'(1) : r_wptr;

  always_ff @(posedge clk_i) begin
    if (w_acc0) r_mem[r_wptr]  <= '{pc: viol_pc_i[0], kind: viol_kind_i[0], port: 1'b0};
    if (w_acc1) r_mem[w_wptr1] <= '{pc: viol_pc_i[1], kind: viol_kind_i[1], port: 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_total <= '0;
      r_drop  <= '0;
    end else begin
      r_wptr  <= r_wptr + c_PTR_W'(w_n_acc);
      r_rptr  <= r_rptr + c_PTR_W'(w_pop);
      r_count <= r_count + c_OCC_W'(w_n_acc) - c_OCC_W'(w_pop);
      if (clr_cnt_i) begin
        r_total <= '0;
        r_drop  <= '0;
      end else begin
        r_total <= sat_add(r_total, w_n_req);
        r_drop  <= sat_add(r_drop, w_n_drop);
      end
    end
  end

  // Head fields are masked when empty so stale storage never leaks out.
  assign w_head      = r_mem[r_rptr];
  assign rec_valid_o = (r_count != '0);
  assign irq_o       = rec_valid_o;
  assign rec_pc_o    = rec_valid_o ? w_head.pc   : '0;
  assign rec_kind_o  = rec_valid_o ? w_head.kind : '0;
  assign rec_port_o  = rec_valid_o ? w_head.port : 1'b0;
  assign total_cnt_o = r_total;
  assign drop_cnt_o  = r_drop;

`ifdef CFI_REPORT_HALT_EN
  logic r_halt_req;

  // A new violation wins over a same-cycle acknowledge so it is not lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_halt_req <= 1'b0;
    end else if (|viol_valid_i) begin
      r_halt_req <= 1'b1;
    end else if (halt_ack_i) begin
      r_halt_req <= 1'b0;
    end
  end

  assign halt_req_o = r_halt_req;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfi_violation_reporter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cfi_violation_reporter: randomized and directed bench with a queue  |
// | based reference model. Revision: 1.0                                   |
// +------------------------------------------------------------------------+
module tb_cfi_violation_reporter;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [1:0]  kind;
    logic        port;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [1:0]       viol_valid_i;
  logic [1:0][63:0] viol_pc_i;
  logic [1:0][1:0]  viol_kind_i;
  logic             rec_valid_o;
  logic             rec_ready_i;
  logic [63:0]      rec_pc_o;
  logic [1:0]       rec_kind_o;
  logic             rec_port_o;
  logic             irq_o;
  logic [CNT_W-1:0] total_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             clr_cnt_i;
`ifdef CFI_REPORT_HALT_EN
  logic             halt_req_o;
  logic             halt_ack_i;
`endif

  cfi_violation_reporter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .viol_valid_i(viol_valid_i), .viol_pc_i(viol_pc_i), .viol_kind_i(viol_kind_i),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_pc_o(rec_pc_o), .rec_kind_o(rec_kind_o), .rec_port_o(rec_port_o),
    .irq_o(irq_o), .total_cnt_o(total_cnt_o), .drop_cnt_o(drop_cnt_o),
    .clr_cnt_i(clr_cnt_i)
`ifdef CFI_REPORT_HALT_EN
    , .halt_req_o(halt_req_o), .halt_ack_i(halt_ack_i)
`endif
  );

  always #5 clk = ~clk;

  rec_t q[$];
  int   m_total = 0;
  int   m_drop  = 0;
  int   n_vec   = 0;
  int   n_err   = 0;

  logic [84:0] dut_vec;
  assign dut_vec = {rec_valid_o, irq_o, rec_pc_o, rec_kind_o, rec_port_o, total_cnt_o, drop_cnt_o};

  function automatic logic [84:0] exp_vec();
    rec_t h = '0;
    logic v = (q.size() != 0);
    if (v) h = q[0];
    return {v, v, h.pc, h.kind, h.port, CNT_W'(m_total), CNT_W'(m_drop)};
  endfunction

  // Apply one cycle of stimulus, advance the model, return at posedge+1.
  task automatic drive(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                       input logic [1:0] k0, input logic [1:0] k1,
                       input logic rdy, input logic clr);
    int free;
    int nd;
    viol_valid_i   = v;
    viol_pc_i[0]   = p0;
    viol_pc_i[1]   = p1;
    viol_kind_i[0] = k0;
    viol_kind_i[1] = k1;
    rec_ready_i    = rdy;
    clr_cnt_i      = clr;
    if (rdy && q.size() != 0) void'(q.pop_front());
    free = DEPTH - q.size();
    nd   = 0;
    if (v[0]) begin
      if (free > 0) begin q.push_back('{pc: p0, kind: k0, port: 1'b0}); free--; end
      else nd++;
    end
    if (v[1]) begin
      if (free > 0) begin q.push_back('{pc: p1, kind: k1, port: 1'b1}); free--; end
      else nd++;
    end
    if (clr) begin
      m_total = 0;
      m_drop  = 0;
    end else begin
      m_total = m_total + int'(v[0]) + int'(v[1]);
      if (m_total > MAXC) m_total = MAXC;
      m_drop = m_drop + nd;
      if (m_drop > MAXC) m_drop = MAXC;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_and_clear();
    for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    viol_valid_i = '0; viol_pc_i = '0; viol_kind_i = '0;
    rec_ready_i = 1'b0; clr_cnt_i = 1'b0;
`ifdef CFI_REPORT_HALT_EN
    halt_ack_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (dut_vec !== '0) begin
      n_err++; $display("FAIL reset_state: got %h expected 0", dut_vec);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
    n_vec++;
    if (dut_vec !== '0) begin
      n_err++; $display("FAIL after_reset_idle: got %h expected 0", dut_vec);
    end
  endtask

  task automatic test_single();
    drain_and_clear();
    drive(2'b01, 64'h8000_0010, 64'h0, 2'd0, 2'd0, 1'b0, 1'b0);
    n_vec++;
    if ({rec_valid_o, irq_o, rec_pc_o, rec_kind_o, rec_port_o, total_cnt_o} !==
        {1'b1, 1'b1, 64'h8000_0010, 2'd0, 1'b0, 8'd1}) begin
      n_err++; $display("FAIL single_capture: got v=%b pc=%h port=%b total=%0d expected v=1 pc=80000010 port=0 total=1",
                        rec_valid_o, rec_pc_o, rec_port_o, total_cnt_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0);
      n_vec++;
      if ({rec_valid_o, rec_pc_o, rec_kind_o, rec_port_o} !== {1'b1, 64'h8000_0010, 2'd0, 1'b0}) begin
        n_err++; $display("FAIL single_stable[%0d]: got v=%b pc=%h expected v=1 pc=80000010", i, rec_valid_o, rec_pc_o);
      end
    end
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    n_vec++;
    if (rec_valid_o !== 1'b0) begin
      n_err++; $display("FAIL single_pop: got valid=%b expected 0", rec_valid_o);
    end
  endtask

  task automatic test_dual();
    drain_and_clear();
    drive(2'b11, 64'h100, 64'h104, 2'd1, 2'd0, 1'b0, 1'b0);
    n_vec++;
    if ({rec_valid_o, rec_pc_o, rec_kind_o, rec_port_o, total_cnt_o} !== {1'b1, 64'h100, 2'd1, 1'b0, 8'd2}) begin
      n_err++; $display("FAIL dual_first: got pc=%h kind=%0d port=%b total=%0d expected pc=100 kind=1 port=0 total=2",
                        rec_pc_o, rec_kind_o, rec_port_o, total_cnt_o);
    end
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    n_vec++;
    if ({rec_valid_o, rec_pc_o, rec_kind_o, rec_port_o} !== {1'b1, 64'h104, 2'd0, 1'b1}) begin
      n_err++; $display("FAIL dual_second: got v=%b pc=%h port=%b expected v=1 pc=104 port=1",
                        rec_valid_o, rec_pc_o, rec_port_o);
    end
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    n_vec++;
    if (rec_valid_o !== 1'b0) begin
      n_err++; $display("FAIL dual_empty: got valid=%b expected 0", rec_valid_o);
    end
  endtask

  task automatic test_full_drop();
    logic [63:0] exp_pc [4];
    logic        exp_port [4];
    exp_pc   = '{64'h14, 64'h18, 64'h1c, 64'h30};
    exp_port = '{1'b1, 1'b0, 1'b1, 1'b0};
    drain_and_clear();
    drive(2'b11, 64'h10, 64'h14, 2'd0, 2'd1, 1'b0, 1'b0);
    drive(2'b11, 64'h18, 64'h1c, 2'd2, 2'd3, 1'b0, 1'b0);
    drive(2'b11, 64'h20, 64'h24, 2'd0, 2'd0, 1'b0, 1'b0);
    n_vec++;
    if ({drop_cnt_o, total_cnt_o, rec_pc_o} !== {8'd2, 8'd6, 64'h10}) begin
      n_err++; $display("FAIL full_drop_two: got drop=%0d total=%0d pc=%h expected drop=2 total=6 pc=10",
                        drop_cnt_o, total_cnt_o, rec_pc_o);
    end
    drive(2'b11, 64'h30, 64'h34, 2'd3, 2'd0, 1'b1, 1'b0);
    n_vec++;
    if ({drop_cnt_o, rec_pc_o} !== {8'd3, 64'h14}) begin
      n_err++; $display("FAIL full_pop_accept: got drop=%0d pc=%h expected drop=3 pc=14", drop_cnt_o, rec_pc_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({rec_valid_o, rec_pc_o, rec_port_o} !== {1'b1, exp_pc[i], exp_port[i]}) begin
        n_err++; $display("FAIL full_drain[%0d]: got v=%b pc=%h port=%b expected v=1 pc=%h port=%b",
                          i, rec_valid_o, rec_pc_o, rec_port_o, exp_pc[i], exp_port[i]);
      end
      drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    end
    n_vec++;
    if (rec_valid_o !== 1'b0) begin
      n_err++; $display("FAIL full_drained: got valid=%b expected 0", rec_valid_o);
    end
  endtask

  task automatic test_saturate_clear();
    drain_and_clear();
    for (int i = 0; i < 150; i++)
      drive(2'b11, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom), 2'($urandom), 1'($urandom), 1'b0);
    n_vec++;
    if (total_cnt_o !== 8'd255) begin
      n_err++; $display("FAIL total_saturate: got %0d expected 255", total_cnt_o);
    end
    n_vec++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL saturate_model: got %h expected %h", dut_vec, exp_vec());
    end
    drive(2'b01, 64'h55, 64'h0, 2'd0, 2'd0, 1'b0, 1'b1);
    n_vec++;
    if ({total_cnt_o, drop_cnt_o} !== 16'd0) begin
      n_err++; $display("FAIL clear_priority: got total=%0d drop=%0d expected 0 0", total_cnt_o, drop_cnt_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom), 2'($urandom),
            1'($urandom), ($urandom_range(0, 31) == 0));
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midop();
    drain_and_clear();
    drive(2'b11, 64'hA0, 64'hA4, 2'd0, 2'd1, 1'b0, 1'b0);
    drive(2'b01, 64'hA8, 64'h0, 2'd2, 2'd0, 1'b0, 1'b0);
    viol_valid_i = '0;
    rec_ready_i  = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (dut_vec !== '0) begin
      n_err++; $display("FAIL async_reset: got %h expected 0", dut_vec);
    end
    q.delete();
    m_total = 0;
    m_drop  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
      n_vec++;
      if (dut_vec !== '0) begin
        n_err++; $display("FAIL post_reset[%0d]: got %h expected 0", i, dut_vec);
      end
    end
  endtask

`ifdef CFI_REPORT_HALT_EN
  task automatic test_halt();
    drive(2'b10, 0, 64'h200, 2'd0, 2'd0, 1'b1, 1'b0);
    n_vec++;
    if (halt_req_o !== 1'b1) begin
      n_err++; $display("FAIL halt_set: got %b expected 1", halt_req_o);
    end
    halt_ack_i = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0);
    halt_ack_i = 1'b0;
    n_vec++;
    if (halt_req_o !== 1'b0) begin
      n_err++; $display("FAIL halt_clear: got %b expected 0", halt_req_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_full_drop();
    test_saturate_clear();
    test_random();
`ifdef CFI_REPORT_HALT_EN
    test_halt();
`endif
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
